sys_trap_ctrl: RTL

Trap/return sequencer for the system privilege register and the PC.
- Takes interrupts, syscalls and return-from-interrupt (RTI) requests at instruction boundaries.
- Saves return PC and prior privilege, drives to_sys / privilage_we / privilage_level to the privilege register, and redirects the PC to a vector or back to the saved PC.
- Sits between instruction decode, the interrupt lines, the PC register and the privilege register. Privilege encoding: 0 = system, 1 = user.

---
 rtl/sys_trap_pkg.sv | 22 ++
 rtl/sys_irq_pending.sv | 44 ++++
 rtl/sys_trap_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sys_trap_pkg.sv
// Shared types and constants for the trap/return sequencer.
// Privilege encoding: 0 = system, 1 = user.
package sys_trap_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSave   = 2'd1,
        StVector = 2'd2,
        StReturn = 2'd3
    } state_e;

    localparam logic [2:0]  CAUSE_SYSCALL   = 3'd4;
    localparam logic [2:0]  CAUSE_ILL_RTI   = 3'd5;
    localparam logic [15:0] DEF_VEC_BASE    = 16'h0010;
    localparam logic [15:0] DEF_SYSCALL_VEC = 16'h0008;

    // Causes 0..3 are interrupt indices; anything with bit 2 set is synchronous.
    function automatic logic is_irq_cause(input logic [2:0] c);
        return ~c[2];
    endfunction

endpackage

// File: rtl/sys_irq_pending.sv
// Sticky interrupt pending register with a lowest-index priority encoder.
// A line asserted in the same cycle its bit is acknowledged stays pending.
module sys_irq_pending #(
    parameter int unsigned N_IRQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             take_i,
    output logic             valid_o,
    output logic [1:0]       idx_o,
    output logic [N_IRQ-1:0] pend_o
);

    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] ack_mask;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = 2'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                valid_o = 1'b1;
                idx_o   = 2'(i);
            end
        end
    end

    always_comb begin
        ack_mask = take_i ? (N_IRQ'(1) << idx_o) : '0;
        pend_d   = (pend_q & ~ack_mask) | irq_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/sys_trap_ctrl.sv
// Trap/return sequencer: takes irqs, syscalls and RTIs at instruction boundaries,
// saves return PC and privilege, and redirects the PC and privilege register.
module sys_trap_ctrl
    import sys_trap_pkg::*;
#(
    parameter int unsigned         ADDR_W      = 16,
    parameter int unsigned         N_IRQ       = 4,
    parameter logic [ADDR_W-1:0]   VEC_BASE    = DEF_VEC_BASE,
    parameter logic [ADDR_W-1:0]   SYSCALL_VEC = DEF_SYSCALL_VEC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IRQ-1:0]  irq_i,
    input  logic              ien_set_i,
    input  logic              instr_boundary_i,
    input  logic              syscall_req_i,
    input  logic              rti_req_i,
    input  logic [ADDR_W-1:0] cur_pc_i,
    input  logic              privilage_i,
    output logic              to_sys_o,
    output logic              privilage_we_o,
    output logic              privilage_level_o,
    output logic              pc_we_o,
    output logic [ADDR_W-1:0] pc_out_o,
    output logic              stall_o,
    output logic              irq_en_o,
    output logic [2:0]        cause_o,
    output logic [ADDR_W-1:0] epc_o
);

    state_e            state_q, state_d;
    logic [2:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              epriv_q, epriv_d;
    logic              irq_en_q, irq_en_d;
    logic              take;
    logic              irq_valid;
    logic [1:0]        irq_idx;
    logic [N_IRQ-1:0]  pend;

    sys_irq_pending #(
        .N_IRQ (N_IRQ)
    ) u_pend (
        .clk     (clk),
        .rst     (rst),
        .irq_i   (irq_i),
        .take_i  (take),
        .valid_o (irq_valid),
        .idx_o   (irq_idx),
        .pend_o  (pend)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cause_q  <= 3'd0;
            epc_q    <= '0;
            epriv_q  <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            epriv_q  <= epriv_d;
            irq_en_q <= irq_en_d;
        end
    end

    // Requests are only looked at in IDLE on a retiring instruction.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (instr_boundary_i) begin
                    if (irq_en_q && irq_valid) begin
                        take    = 1'b1;
                        cause_d = {1'b0, irq_idx};
                        state_d = StSave;
                    end else if (syscall_req_i) begin
                        cause_d = CAUSE_SYSCALL;
                        state_d = StSave;
                    end else if (rti_req_i && !privilage_i) begin
                        state_d = StReturn;
                    end else if (rti_req_i) begin
                        cause_d = CAUSE_ILL_RTI;
                        state_d = StSave;
                    end
                end
            end
            StSave:   state_d = StVector;
            StVector: state_d = StIdle;
            StReturn: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        epc_d    = epc_q;
        epriv_d  = epriv_q;
        irq_en_d = irq_en_q;
        unique case (state_q)
            StIdle:   if (ien_set_i) irq_en_d = 1'b1;
            StSave: begin
                epc_d    = cur_pc_i;
                epriv_d  = privilage_i;
                irq_en_d = 1'b0;
            end
            StReturn: irq_en_d = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        to_sys_o          = 1'b0;
        privilage_we_o    = 1'b0;
        privilage_level_o = 1'b0;
        pc_we_o           = 1'b0;
        pc_out_o          = '0;
        unique case (state_q)
            StSave: to_sys_o = 1'b1;
            StVector: begin
                pc_we_o  = 1'b1;
                pc_out_o = is_irq_cause(cause_q) ?
                           VEC_BASE + ADDR_W'({cause_q[1:0], 2'b00}) : SYSCALL_VEC;
            end
            StReturn: begin
                privilage_we_o    = 1'b1;
                privilage_level_o = epriv_q;
                pc_we_o           = 1'b1;
                pc_out_o          = epc_q;
            end
            default: ;
        endcase
    end

    assign stall_o  = (state_q != StIdle);
    assign irq_en_o = irq_en_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;

endmodule
